// File: rtl/dds_pkg.sv
// dds_pkg: shared FSM encoding, config address map and default widths
// for the DDS frequency/amplitude sweep controller.
package dds_pkg;

  localparam int FW_WIDTH_DEF    = 28;
  localparam int DAC_WIDTH_DEF   = 12;
  localparam int DWELL_WIDTH_DEF = 16;
  localparam int CFG_ADDR_WIDTH  = 3;
  localparam int CFG_DATA_WIDTH  = 32;

  localparam logic [CFG_ADDR_WIDTH-1:0] CFG_F_START = 3'd0;
  localparam logic [CFG_ADDR_WIDTH-1:0] CFG_F_STOP  = 3'd1;
  localparam logic [CFG_ADDR_WIDTH-1:0] CFG_F_STEP  = 3'd2;
  localparam logic [CFG_ADDR_WIDTH-1:0] CFG_DWELL   = 3'd3;
  localparam logic [CFG_ADDR_WIDTH-1:0] CFG_AMPL    = 3'd4;
  localparam logic [CFG_ADDR_WIDTH-1:0] CFG_MODE    = 3'd5;

  typedef enum logic {
    IDLE  = 1'b0,
    DWELL = 1'b1
  } sweepState_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } sweepDir_e;

endpackage

// File: rtl/dds_dwell_timer.sv
// dds_dwell_timer: loadable down-counter that saturates at zero and flags
// when the current sweep point has used up its dwell.
module dds_dwell_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] loadVal_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= loadVal_i;
    end else if (en_i && (count_q != '0)) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: config register file plus a stepped frequency sweep that
// drives the DDS tuning and amplitude words. DDS_SWEEP_PINGPONG_EN adds a
// down leg that returns from f_stop to f_start.
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int FW_WIDTH    = FW_WIDTH_DEF,
  parameter int DAC_WIDTH   = DAC_WIDTH_DEF,
  parameter int DWELL_WIDTH = DWELL_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [CFG_ADDR_WIDTH-1:0] cfg_addr,
  input  logic [CFG_DATA_WIDTH-1:0] cfg_data,
  input  logic                      start,
  input  logic                      abort,
  output logic [FW_WIDTH-1:0]       Freq_KW,
  output logic [DAC_WIDTH-1:0]      Ampl_KW,
  output logic                      kw_update,
  output logic                      busy,
  output logic                      done
);

  sweepState_e           state_q;
  logic [FW_WIDTH-1:0]   fStart_q;
  logic [FW_WIDTH-1:0]   fStop_q;
  logic [FW_WIDTH-1:0]   fStep_q;
  logic [DWELL_WIDTH-1:0] dwell_q;
  logic [DAC_WIDTH-1:0]  cfgAmpl_q;
  logic                  mode_q;
  logic [FW_WIDTH-1:0]   freqKw_q;
  logic [DAC_WIDTH-1:0]  amplKw_q;
  logic                  kwUpdate_q;
  logic                  done_q;

  logic                  cfgWrite;
  logic                  startAccept;
  logic                  dwellZero;
  logic                  expire;
  logic                  atTop;
  logic [FW_WIDTH:0]     upSum;
  logic [FW_WIDTH-1:0]   upNext;
  logic                  unusedCfgBits;

`ifdef DDS_SWEEP_PINGPONG_EN
  sweepDir_e             dir_q;
  logic                  atBottom;
  logic [FW_WIDTH:0]     downDiff;
  logic [FW_WIDTH-1:0]   downNext;
`endif

  assign cfgWrite    = cfg_valid && (state_q == IDLE);
  assign startAccept = (state_q == IDLE) && start && !abort;
  assign expire      = (state_q == DWELL) && !abort && dwellZero;
  assign unusedCfgBits = ^cfg_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fStart_q  <= '0;
      fStop_q   <= '0;
      fStep_q   <= '0;
      dwell_q   <= '0;
      cfgAmpl_q <= '0;
      mode_q    <= 1'b0;
    end else if (cfgWrite) begin
      case (cfg_addr)
        CFG_F_START: fStart_q  <= cfg_data[FW_WIDTH-1:0];
        CFG_F_STOP:  fStop_q   <= cfg_data[FW_WIDTH-1:0];
        CFG_F_STEP:  fStep_q   <= cfg_data[FW_WIDTH-1:0];
        CFG_DWELL:   dwell_q   <= cfg_data[DWELL_WIDTH-1:0];
        CFG_AMPL:    cfgAmpl_q <= cfg_data[DAC_WIDTH-1:0];
        CFG_MODE:    mode_q    <= cfg_data[0];
        default:     ;
      endcase
    end
  end

  // Step sums are one bit wider so a wrap past the top of the word clamps
  // to f_stop instead of landing back near zero; a zero step jumps straight
  // to the end of the leg rather than stalling.
  always_comb begin
    upSum  = {1'b0, freqKw_q} + {1'b0, fStep_q};
    upNext = upSum[FW_WIDTH-1:0];
    if ((fStep_q == '0) || (upSum >= {1'b0, fStop_q})) begin
      upNext = fStop_q;
    end
  end

  assign atTop = (freqKw_q >= fStop_q);

`ifdef DDS_SWEEP_PINGPONG_EN
  always_comb begin
    downDiff = {1'b0, freqKw_q} - {1'b0, fStep_q};
    downNext = downDiff[FW_WIDTH-1:0];
    if ((fStep_q == '0) || downDiff[FW_WIDTH] || (downDiff[FW_WIDTH-1:0] <= fStart_q)) begin
      downNext = fStart_q;
    end
  end

  assign atBottom = (freqKw_q <= fStart_q);
`endif

  dds_dwell_timer #(
    .WIDTH(DWELL_WIDTH)
  ) u_dwellTimer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (startAccept || expire),
    .en_i     ((state_q == DWELL) && !abort),
    .loadVal_i(dwell_q),
    .zero_o   (dwellZero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      freqKw_q   <= '0;
      amplKw_q   <= '0;
      kwUpdate_q <= 1'b0;
      done_q     <= 1'b0;
`ifdef DDS_SWEEP_PINGPONG_EN
      dir_q      <= DIR_UP;
`endif
    end else begin
      kwUpdate_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (startAccept) begin
            freqKw_q   <= fStart_q;
            amplKw_q   <= cfgAmpl_q;
            kwUpdate_q <= 1'b1;
            state_q    <= DWELL;
`ifdef DDS_SWEEP_PINGPONG_EN
            dir_q      <= DIR_UP;
`endif
          end
        end
        DWELL: begin
          if (abort) begin
            state_q <= IDLE;
          end else if (dwellZero) begin
`ifdef DDS_SWEEP_PINGPONG_EN
            // A range with f_stop <= f_start has no down leg to bounce into.
            if (dir_q == DIR_UP) begin
              if (!atTop) begin
                freqKw_q   <= upNext;
                kwUpdate_q <= 1'b1;
              end else if (!atBottom) begin
                dir_q      <= DIR_DOWN;
                freqKw_q   <= downNext;
                kwUpdate_q <= 1'b1;
              end else if (mode_q) begin
                freqKw_q   <= fStart_q;
                kwUpdate_q <= 1'b1;
              end else begin
                state_q <= IDLE;
                done_q  <= 1'b1;
              end
            end else begin
              if (!atBottom) begin
                freqKw_q   <= downNext;
                kwUpdate_q <= 1'b1;
              end else if (mode_q) begin
                dir_q      <= DIR_UP;
                freqKw_q   <= upNext;
                kwUpdate_q <= 1'b1;
              end else begin
                state_q <= IDLE;
                done_q  <= 1'b1;
              end
            end
`else
            if (!atTop) begin
              freqKw_q   <= upNext;
              kwUpdate_q <= 1'b1;
            end else if (mode_q) begin
              freqKw_q   <= fStart_q;
              kwUpdate_q <= 1'b1;
            end else begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Freq_KW   = freqKw_q;
  assign Ampl_KW   = amplKw_q;
  assign kw_update = kwUpdate_q;
  assign done      = done_q;
  assign busy      = (state_q != IDLE);
  assign cfg_ready = (state_q == IDLE);

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb_dds_sweep_ctrl: directed vector table, multi-cycle corner sequences and
// randomized sweeps compared against a point-list reference model.
`timescale 1ns/1ps
module tb_dds_sweep_ctrl;

  localparam int FW = 28;
  localparam int AW = 12;
  localparam int DW = 16;

  logic          clk;
  logic          rst_n;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [2:0]    cfg_addr;
  logic [31:0]   cfg_data;
  logic          start;
  logic          abort;
  logic [FW-1:0] Freq_KW;
  logic [AW-1:0] Ampl_KW;
  logic          kw_update;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;
  longint refPts[$];

  typedef struct {
    logic [FW-1:0] fs;
    logic [FW-1:0] fstop;
    logic [FW-1:0] fstep;
    int            dwell;
    logic [AW-1:0] ampl;
    int            expDone;
    logic [FW-1:0] expLast;
  } vec_t;

  vec_t          vecs[5];
  int            doneAt;
  logic [FW-1:0] lastF;
  logic [31:0]   r;
  logic [FW-1:0] rFs, rStop, rStep;
  int            rDwell;
  int            expBasicDone;
  logic [FW-1:0] expContK16;

  dds_sweep_ctrl #(
    .FW_WIDTH   (FW),
    .DAC_WIDTH  (AW),
    .DWELL_WIDTH(DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .start     (start),
    .abort     (abort),
    .Freq_KW   (Freq_KW),
    .Ampl_KW   (Ampl_KW),
    .kw_update (kw_update),
    .busy      (busy),
    .done      (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic writeCfg(input logic [2:0] a, input logic [31:0] d);
    cfg_valid = 1'b1;
    cfg_addr  = a;
    cfg_data  = d;
    checkOutput($sformatf("cfg_ready addr%0d", a), 64'(cfg_ready), 64'd1);
    tick;
    cfg_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [FW-1:0] fs, input logic [FW-1:0] fstop,
                               input logic [FW-1:0] fstep, input int dwell,
                               input logic [31:0] ampl, input logic mode);
    writeCfg(3'd0, 32'(fs));
    writeCfg(3'd1, 32'(fstop));
    writeCfg(3'd2, 32'(fstep));
    writeCfg(3'd3, 32'(dwell));
    writeCfg(3'd4, ampl);
    writeCfg(3'd5, {31'b0, mode});
  endtask

  // Reference: the list of tuning words one non-continuous sweep visits.
  task automatic buildModel(input longint fs, input longint fstop, input longint fstep);
    longint cur, nxt;
    refPts.delete();
    refPts.push_back(fs);
    cur = fs;
    while (cur < fstop) begin
      nxt = (fstep == 0 || cur + fstep > fstop) ? fstop : cur + fstep;
      refPts.push_back(nxt);
      cur = nxt;
    end
`ifdef DDS_SWEEP_PINGPONG_EN
    if (fs < fstop) begin
      while (cur > fs) begin
        nxt = (fstep == 0 || cur - fstep < fs) ? fs : cur - fstep;
        refPts.push_back(nxt);
        cur = nxt;
      end
    end
`endif
  endtask

  task automatic sweepCheck(input string tag, input int dwell, input logic [AW-1:0] ampl,
                            output int doneAtO, output logic [FW-1:0] lastFreq);
    int n, total, idx;
    n = refPts.size();
    total = n * (dwell + 1);
    doneAtO = -1;
    start = 1'b1;
    tick;
    start = 1'b0;
    checkOutput($sformatf("%s ampl", tag), 64'(Ampl_KW), 64'(ampl));
    for (int k = 0; k <= total + 1; k++) begin
      if (k > 0) tick;
      idx = k / (dwell + 1);
      if (idx >= n) idx = n - 1;
      checkOutput($sformatf("%s freq k=%0d", tag, k), 64'(Freq_KW), 64'(refPts[idx]));
      checkOutput($sformatf("%s kw_update k=%0d", tag, k), 64'(kw_update),
                  64'((k < total) && (k % (dwell + 1) == 0)));
      checkOutput($sformatf("%s busy k=%0d", tag, k), 64'(busy), 64'(k < total));
      checkOutput($sformatf("%s done k=%0d", tag, k), 64'(done), 64'(k == total));
      if (done === 1'b1 && doneAtO < 0) doneAtO = k;
    end
    lastFreq = Freq_KW;
  endtask

  initial begin
`ifdef DDS_SWEEP_PINGPONG_EN
    vecs[0] = '{28'd100, 28'd130, 28'd10, 3, 12'h7FF, 28, 28'd100};
    vecs[1] = '{28'd100, 28'd130, 28'd20, 3, 12'h7FF, 20, 28'd100};
    vecs[2] = '{28'hFFFFFF0, 28'hFFFFFFF, 28'h20, 0, 12'h123, 3, 28'hFFFFFF0};
    vecs[3] = '{28'd200, 28'd100, 28'd10, 2, 12'h055, 3, 28'd200};
    vecs[4] = '{28'd50, 28'd90, 28'd0, 1, 12'hABC, 6, 28'd50};
    expBasicDone = 28;
    expContK16   = 28'd120;
`else
    vecs[0] = '{28'd100, 28'd130, 28'd10, 3, 12'h7FF, 16, 28'd130};
    vecs[1] = '{28'd100, 28'd130, 28'd20, 3, 12'h7FF, 12, 28'd130};
    vecs[2] = '{28'hFFFFFF0, 28'hFFFFFFF, 28'h20, 0, 12'h123, 2, 28'hFFFFFFF};
    vecs[3] = '{28'd200, 28'd100, 28'd10, 2, 12'h055, 3, 28'd200};
    vecs[4] = '{28'd50, 28'd90, 28'd0, 1, 12'hABC, 4, 28'd90};
    expBasicDone = 16;
    expContK16   = 28'd100;
`endif

    rst_n = 1'b0; cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0;
    start = 1'b0; abort = 1'b0;
    #12;
    checkOutput("reset Freq_KW", 64'(Freq_KW), 64'd0);
    checkOutput("reset Ampl_KW", 64'(Ampl_KW), 64'd0);
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset cfg_ready", 64'(cfg_ready), 64'd1);
    checkOutput("reset kw_update", 64'(kw_update), 64'd0);
    checkOutput("reset done", 64'(done), 64'd0);
    #6;
    rst_n = 1'b1;
    tick;

    // Unprogrammed registers give a single zero point lasting one cycle.
    buildModel(0, 0, 0);
    sweepCheck("zeroCfg", 0, 12'h000, doneAt, lastF);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].fs, vecs[i].fstop, vecs[i].fstep, vecs[i].dwell, 32'(vecs[i].ampl), 1'b0);
      buildModel(64'(vecs[i].fs), 64'(vecs[i].fstop), 64'(vecs[i].fstep));
      sweepCheck($sformatf("vec%0d", i), vecs[i].dwell, vecs[i].ampl, doneAt, lastF);
      checkOutput($sformatf("vec%0d done cycle", i), 64'(doneAt), 64'(vecs[i].expDone));
      checkOutput($sformatf("vec%0d final freq", i), 64'(lastF), 64'(vecs[i].expLast));
    end

    applyStimulus(28'd100, 28'd130, 28'd10, 3, 32'h7FF, 1'b0);
    writeCfg(3'd6, 32'hFFFF_FFFF);
    writeCfg(3'd7, 32'hFFFF_FFFF);
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (4) tick;
    cfg_valid = 1'b1; cfg_addr = 3'd0; cfg_data = 32'd999; start = 1'b1;
    tick;
    checkOutput("lockout cfg_ready", 64'(cfg_ready), 64'd0);
    checkOutput("lockout freq", 64'(Freq_KW), 64'd110);
    cfg_valid = 1'b0; start = 1'b0;
    doneAt = -1;
    for (int k = 6; k <= 40; k++) begin
      tick;
      if (done === 1'b1 && doneAt < 0) doneAt = k;
    end
    checkOutput("lockout done cycle", 64'(doneAt), 64'(expBasicDone));
    buildModel(100, 130, 10);
    sweepCheck("afterLockout", 3, 12'h7FF, doneAt, lastF);

    applyStimulus(28'd100, 28'd130, 28'd10, 3, 32'h1234_57FF, 1'b1);
    start = 1'b1;
    tick;
    start = 1'b0;
    checkOutput("cont ampl truncated", 64'(Ampl_KW), 64'h7FF);
    for (int k = 1; k <= 16; k++) begin
      tick;
      checkOutput($sformatf("cont done k=%0d", k), 64'(done), 64'd0);
    end
    checkOutput("cont freq k=16", 64'(Freq_KW), 64'(expContK16));
    checkOutput("cont kw_update k=16", 64'(kw_update), 64'd1);
    checkOutput("cont busy k=16", 64'(busy), 64'd1);
    repeat (4) tick;
    checkOutput("cont freq k=20", 64'(Freq_KW), 64'd110);
    checkOutput("cont kw_update k=20", 64'(kw_update), 64'd1);
    tick;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    checkOutput("abort busy", 64'(busy), 64'd0);
    checkOutput("abort freq", 64'(Freq_KW), 64'd110);
    checkOutput("abort ampl", 64'(Ampl_KW), 64'h7FF);
    checkOutput("abort done", 64'(done), 64'd0);
    checkOutput("abort cfg_ready", 64'(cfg_ready), 64'd1);
    for (int k = 0; k < 3; k++) begin
      tick;
      checkOutput($sformatf("post-abort done %0d", k), 64'(done), 64'd0);
      checkOutput($sformatf("post-abort freq %0d", k), 64'(Freq_KW), 64'd110);
    end

    start = 1'b1; abort = 1'b1;
    tick;
    start = 1'b0; abort = 1'b0;
    checkOutput("abort-over-start busy", 64'(busy), 64'd0);
    checkOutput("abort-over-start kw_update", 64'(kw_update), 64'd0);
    checkOutput("abort-over-start freq", 64'(Freq_KW), 64'd110);

    applyStimulus(28'd100, 28'd130, 28'd10, 3, 32'h7FF, 1'b0);
    start = 1'b1;
    tick;
    start = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset Freq_KW", 64'(Freq_KW), 64'd0);
    checkOutput("midreset Ampl_KW", 64'(Ampl_KW), 64'd0);
    checkOutput("midreset busy", 64'(busy), 64'd0);
    checkOutput("midreset cfg_ready", 64'(cfg_ready), 64'd1);
    checkOutput("midreset kw_update", 64'(kw_update), 64'd0);
    #2;
    rst_n = 1'b1;
    tick;

    for (int it = 0; it < 8; it++) begin
      r = $urandom_range(0, 32'h0FFF_FFFF);
      rFs = r[FW-1:0];
      case (it % 4)
        0: begin r = 32'(rFs) + $urandom_range(0, 150); rStop = r[FW-1:0]; end
        1: begin r = 32'(rFs) - $urandom_range(1, 20); rStop = r[FW-1:0]; end
        2: begin
          r = 32'h0FFF_FFFF - $urandom_range(0, 100);
          rFs = r[FW-1:0];
          rStop = 28'hFFF_FFFF;
        end
        default: begin r = 32'(rFs) + $urandom_range(0, 60); rStop = r[FW-1:0]; end
      endcase
      if (it % 4 == 2) r = $urandom_range(50, 32'h0FFF_FFFF);
      else r = $urandom_range(0, 25);
      rStep = r[FW-1:0];
      rDwell = int'($urandom_range(0, 3));
      r = $urandom;
      applyStimulus(rFs, rStop, rStep, rDwell, r, 1'b0);
      buildModel(64'(rFs), 64'(rStop), 64'(rStep));
      sweepCheck($sformatf("rand%0d", it), rDwell, r[AW-1:0], doneAt, lastF);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

Frequency/amplitude sweep controller for the DDS core. It holds a small register file written over a valid/ready config port. On `start` it sequences the DDS tuning word from a start frequency to a stop frequency in fixed steps, holding each point for a programmable dwell. It sits between the control source and the DDS instance in `dds_top`, driving its `Freq_KW` and `Ampl_KW` inputs in place of the current constant/ctrl-derived tie-offs.

## Interface
- `FW_WIDTH`, 28: frequency tuning-word width.
- `DAC_WIDTH`, 12: amplitude-word width.
- `DWELL_WIDTH`, 16: dwell counter width.

- `clk` in 1: single system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cfg_valid` in 1: config write request.
- `cfg_ready` out 1: config write accepted; high only in IDLE.
- `cfg_addr` in 3: 0=f_start, 1=f_stop, 2=f_step, 3=dwell, 4=ampl, 5=mode (bit0 = continuous).
- `cfg_data` in 32: write data, LSB-aligned, truncated to the field width.
- `start` in 1: begin sweep (level sampled).
- `abort` in 1: stop sweep.
- `Freq_KW` out FW_WIDTH: tuning word to the DDS.
- `Ampl_KW` out DAC_WIDTH: amplitude word to the DDS.
- `kw_update` out 1: one-cycle pulse when the outputs change.
- `busy` out 1: sweep in progress.
- `done` out 1: one-cycle pulse at sweep completion.

## Operation
- FSM states: IDLE, DWELL. Step and end logic is evaluated on the DWELL expiry edge.
- Config write: a write occurs when `cfg_valid` and `cfg_ready` are both high.
  - Addresses 6–7 are acknowledged and ignored.
  - Writes never alter a running sweep.
- IDLE with `start` and no `abort`:
  - `Freq_KW`←f_start, `Ampl_KW`←ampl, `dwell_cnt`←dwell.
  - Pulse `kw_update` and go to DWELL.
- DWELL: while `dwell_cnt`≠0, decrement. When `dwell_cnt`=0, let cur = `Freq_KW`:
  - **End** (cur ≥ f_stop, unsigned):
    - Continuous mode: `Freq_KW`←f_start, reload `dwell_cnt`, pulse `kw_update`, stay in DWELL.
    - Otherwise: go to IDLE, pulse `done`, and hold `Freq_KW`.
  - **Else**: `Freq_KW` ← min(cur+f_step, f_stop).
    - The sum is computed FW_WIDTH+1 bits wide, so overflow clamps to f_stop.
    - f_step=0 jumps directly to f_stop.
    - Reload `dwell_cnt` and pulse `kw_update`.
- f_stop < f_start: a single point at f_start, then end.
- `abort` in any state: IDLE on the next edge, no `done`. `Freq_KW` and `Ampl_KW` hold their values. `abort` wins over a simultaneous `start`.
- `start` while busy is ignored.
- `busy` = (state ≠ IDLE). `cfg_ready` = (state = IDLE).

## Timing
- Reset values:
  - `Freq_KW`=0, `Ampl_KW`=0, all config registers 0.
  - `kw_update`=0, `done`=0, `busy`=0, `cfg_ready`=1.
- Outputs are registered. `Freq_KW` changes on the edge that samples `start`.
- Each point is held dwell+1 cycles; dwell=0 gives one cycle per point.
- An N-point sweep asserts `done` exactly N·(dwell+1) cycles after the first `kw_update`. `busy` falls on the same edge.
- Reset mid-sweep: immediate return to the reset values.
- The DDS runs on the divided clock. Software must program dwell+1 ≥ the divider ratio so that every point is sampled.

## Configuration
- Macro `DDS_SWEEP_PINGPONG_EN`.
- Defined: on reaching f_stop, the direction reverses. Steps go down as max(cur−f_step, f_start), with underflow clamping to f_start.
  - Non-continuous mode ends, with `done`, on returning to f_start.
  - Continuous mode bounces indefinitely.
  - Adds a 1-bit direction register, reset to up.
- Undefined: up-only behaviour as described above.

## Structure
- Shared package `dds_pkg`: FSM state encoding, cfg address constants, default widths.
- One sub-module `dds_dwell_timer`: loadable down-counter with load/enable inputs and a `zero` flag.
- All other logic lives in `dds_sweep_ctrl`.

## Test plan
- **Reset:** assert `rst_n` low mid-cycle → `Freq_KW`=0, `Ampl_KW`=0, `busy`=0, `cfg_ready`=1, asynchronously.
- **Basic sweep:** f_start=100, f_stop=130, f_step=10, dwell=3, ampl=0x7FF, mode=0, then `start` → `Freq_KW` goes 100,110,120,130, each held 4 cycles. `done` pulses 16 cycles after the first `kw_update`. `Ampl_KW`=0x7FF.
- **Clamp:** f_step=20, same setup → 100,120,130, then `done`. f_start=0xFFFFFF0, f_stop=0xFFFFFFF, f_step=0x20 → clamps to 0xFFFFFFF with no wrap.
- **Continuous + abort:** mode=1 → after 130 the sequence returns to 100. Assert `abort` in dwell of 110 → `busy`=0 next cycle, `Freq_KW` stays 110, no `done`.
- **Busy lockout:** `cfg_valid` with addr 0 during the sweep → `cfg_ready`=0 and f_start is unchanged after the sweep. A `start` pulse mid-sweep has no effect.
- **`DDS_SWEEP_PINGPONG_EN` defined, basic setup:** 100,110,120,130,120,110,100, then `done` after 28 cycles.
